// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: load funct3 codes, FSM encoding, register address width.
package wb_pkg;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;
endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Halfword selection uses addr_lo[1] only; unknown funct3 codes return the full word.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      FUNCT3_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_LH:  value = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_LHU: value = {{(XLEN-16){1'b0}}, half_sel};
      default:    value = word;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU results or extended load data to the register-file write port.
// Latency: write port updates one cycle after the result is available; loads stall (in_ready=0) until mem_rdata_valid.
// Optional registered write-port bypass copy is enabled with `define WB_BYPASS_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_ADDR_W-1:0]  in_rd,
  input  logic                   in_reg_write,
  input  logic                   in_is_load,
  input  logic [2:0]             in_funct3,
  input  logic [1:0]             in_addr_lo,
  input  logic [XLEN-1:0]        in_result,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   mem_rdata_valid,
  output logic [REG_ADDR_W-1:0]  addr_rd,
  output logic [XLEN-1:0]        data_rd,
  output logic                   write_enable,
  output logic [COUNT_WIDTH-1:0] retire_count,
  output logic                   bypass_valid,
  output logic [REG_ADDR_W-1:0]  bypass_rd,
  output logic [XLEN-1:0]        bypass_data
);
  wb_state_t             state, state_nxt;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic                  ld_reg_write;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_addr_lo;
  logic [XLEN-1:0]       ld_value;

  logic                  commit;
  logic [REG_ADDR_W-1:0] commit_rd;
  logic [XLEN-1:0]       commit_dat;
  logic                  commit_we;
  logic                  capture;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .word    (mem_rdata),
    .value   (ld_value)
  );

  assign in_ready = (state == WB_IDLE);

  always_comb begin
    state_nxt  = state;
    commit     = 1'b0;
    capture    = 1'b0;
    commit_rd  = in_rd;
    commit_dat = in_result;
    commit_we  = in_reg_write && (in_rd != '0);
    case (state)
      WB_IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            capture   = 1'b1;
            state_nxt = WB_WAIT_MEM;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WB_WAIT_MEM: begin
        commit_rd  = ld_rd;
        commit_dat = ld_value;
        commit_we  = ld_reg_write && (ld_rd != '0);
        if (mem_rdata_valid) begin
          commit    = 1'b1;
          state_nxt = WB_IDLE;
        end
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= WB_IDLE;
      ld_rd        <= '0;
      ld_reg_write <= 1'b0;
      ld_funct3    <= '0;
      ld_addr_lo   <= '0;
      addr_rd      <= '0;
      data_rd      <= '0;
      write_enable <= 1'b0;
      retire_count <= '0;
    end else begin
      state        <= state_nxt;
      write_enable <= commit && commit_we;
      if (capture) begin
        ld_rd        <= in_rd;
        ld_reg_write <= in_reg_write;
        ld_funct3    <= in_funct3;
        ld_addr_lo   <= in_addr_lo;
      end
      if (commit) begin
        addr_rd      <= commit_rd;
        data_rd      <= commit_dat;
        retire_count <= retire_count + 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // One-cycle-late copy of the write port covers the register file's read-during-write staleness.
  always_ff @(posedge clock) begin
    if (reset) begin
      bypass_valid <= 1'b0;
      bypass_rd    <= '0;
      bypass_data  <= '0;
    end else begin
      bypass_valid <= write_enable;
      bypass_rd    <= addr_rd;
      bypass_data  <= data_rd;
    end
  end
`else
  assign bypass_valid = 1'b0;
  assign bypass_rd    = '0;
  assign bypass_data  = '0;
`endif
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; sits directly upstream of the register file.
- Accepts retiring instructions from the memory stage over a valid/ready handshake. For loads, waits for synchronous data-memory read data, then aligns and sign/zero-extends it.
- Drives the register-file write port (addr_rd, data_rd, write_enable) one cycle after the result is available.
- Maintains a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- COUNT_WIDTH, 64, retire counter width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; combinational, equals (state==IDLE)
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load width/sign encoding
- in_addr_lo  in  2  low byte-address bits of load
- in_result  in  XLEN  ALU/link result for non-loads
- mem_rdata  in  XLEN  data-memory read word
- mem_rdata_valid  in  1  mem_rdata valid this cycle
- addr_rd  out  5  register-file write address
- data_rd  out  XLEN  register-file write data
- write_enable  out  1  register-file write strobe
- retire_count  out  COUNT_WIDTH  instructions committed
- bypass_valid  out  1  see Optional Feature
- bypass_rd  out  5  see Optional Feature
- bypass_data  out  XLEN  see Optional Feature

Behaviour:
- One clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values: state=IDLE, addr_rd=0, data_rd=0, write_enable=0, retire_count=0, bypass_* = 0. in_ready=1 in the cycle after reset deasserts.
- FSM states:
  - IDLE: in_ready=1. Accept when in_valid.
    - Non-load accepted at edge N: at N+1, addr_rd=in_rd, data_rd=in_result, write_enable=in_reg_write && in_rd!=0. retire_count increments at N+1. Stay IDLE.
    - Load accepted: capture rd, reg_write, funct3, addr_lo; go WAIT_MEM; no write that cycle.
  - WAIT_MEM: in_ready=0.
    - mem_rdata_valid sampled high at edge M: at M+1, write the extracted value to captured rd (same rd!=0 and reg_write gating). retire_count increments. Return to IDLE.
    - Otherwise hold indefinitely.
- mem_rdata_valid in IDLE is ignored.
- write_enable is a single-cycle pulse per committed instruction. Otherwise 0; addr_rd and data_rd hold their last values.
- Back-to-back non-loads: one commit per cycle, full throughput.
- Load extraction:
  - funct3 000 LB: byte addr_lo, sign-extended.
  - 100 LBU: byte addr_lo, zero-extended.
  - 001 LH: half selected by addr_lo[1], sign-extended.
  - 101 LHU: half selected by addr_lo[1], zero-extended.
  - 010 LW: full word.
  - Any other funct3 is treated as LW.
  - addr_lo[0] is ignored for halfwords; misalignment is not trapped here.
- rd=0: instruction still retires and the counter increments; write_enable stays 0.
- retire_count wraps modulo 2^COUNT_WIDTH.
- Reset mid-WAIT_MEM drops the pending load: no write and no count. A concurrent mem_rdata_valid is ignored.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Registered copy of the previous cycle's write port: bypass_valid=write_enable delayed 1 cycle, bypass_rd and bypass_data likewise.
  - Decode compares its source address with bypass_rd to cover the register file's read-during-write staleness (synchronous read returns the old value when the same address is written on the same edge).
- Undefined: bypass_valid, bypass_rd and bypass_data are tied to 0; no extra flops.

Decomposition:
- Package wb_pkg:
  - funct3 load constants FUNCT3_LB/LH/LW/LBU/LHU.
  - State encoding WB_IDLE / WB_WAIT_MEM.
  - Register-address width constant REG_ADDR_W=5.
- Sub-module load_extend: combinational; inputs funct3, addr_lo, word; output XLEN extended value. Instantiated once.

Test Plan:
- Non-load, rd=5, result 0x1234_5678 accepted at edge N: at N+1 addr_rd=5, data_rd=0x12345678, write_enable=1; at N+2 write_enable=0; retire_count=1.
- LB, addr_lo=3, mem_rdata=0x80FF_0000 after 3 wait cycles: in_ready=0 throughout the wait; write data 0xFFFF_FF80. The same case as LBU writes 0x0000_0080.
- LH addr_lo=2, mem_rdata=0x8001_7FFF: write data 0xFFFF_8001. LHU addr_lo=0 on the same word: write data 0x0000_7FFF.
- Non-load with rd=0 and reg_write=1: write_enable stays 0; retire_count still increments.
- Reset asserted in WAIT_MEM coincident with mem_rdata_valid: no write next cycle, retire_count=0, in_ready=1.
- WB_BYPASS_EN defined, two back-to-back writes (rd=3 0xA, rd=4 0xB): bypass shows rd=3/0xA one cycle after the first write, then rd=4/0xB. Undefined: bypass_* stay 0.
